// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM state codes and line levels.
package fifo_uart_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_START  = 3'd3;
    localparam state_t S_DATA   = 3'd4;
    localparam state_t S_PARITY = 3'd5;
    localparam state_t S_STOP   = 3'd6;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign bit_tick = (count_reg == LAST_CNT) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear || bit_tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and shifts them out as UART frames (start, data LSB first,
// optional parity, 1 or 2 stop bits). tx is registered from next-state logic so it moves with the state.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]        bit_idx_reg, bit_idx_next;
    logic [1:0]              stop_cnt_reg, stop_cnt_next;
    logic                    parity_reg, parity_next;
    logic                    tx_reg, tx_next;
    logic                    done_reg, done_next;
    logic                    bit_tick;
    logic                    baud_clear;

    // The bit timer only runs while a frame is on the line.
    assign baud_clear = (state_reg == S_IDLE) || (state_reg == S_FETCH) || (state_reg == S_WAIT);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    assign fifo_r_en  = (state_reg == S_FETCH);
    assign busy       = (state_reg != S_IDLE);
    assign tx         = tx_reg;
    assign frame_done = done_reg;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                shift_next    = fifo_data;
                parity_next   = (^fifo_data) ^ (PARITY_ODD != 0);
                bit_idx_next  = '0;
                stop_cnt_next = '0;
                state_next    = S_START;
            end
            S_START: begin
                if (bit_tick) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Line level follows the state being entered, so tx and state change on the same edge.
        case (state_next)
            S_START:  tx_next = LINE_START;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= LINE_IDLE;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations (8N1, 8E2, 8O2) fed by simple FIFO models,
// checked cycle by cycle against a frame-level waveform model plus directed frame tables.
module tb_fifo_uart_tx;

    localparam int NI    = 3;
    localparam int CPB   = 4;
    localparam int DEPTH = 64;

    typedef logic [3:0] obs_t;  // {tx, busy, fifo_r_en, frame_done}
    typedef struct {
        int         inst;
        logic [7:0] word;
        string      bits;       // expected line level per bit period, first bit first
    } vec_t;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [NI-1:0]   fifo_empty;
    logic [NI-1:0]   fifo_r_en;
    logic [NI-1:0]   tx;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   frame_done;
    logic [7:0]      fifo_data [NI];

    logic [7:0]      mem [NI][DEPTH];
    int              wr_ptr [NI];
    int              rd_ptr [NI] = '{default: 0};

    obs_t            frame_buf [NI][64];
    int              frame_len [NI];
    int              frame_pos [NI];
    int              model_rd [NI];
    obs_t            exp_obs [NI];
    int              fill_n;

    int              ren_cnt [NI];
    int              done_cnt [NI];
    int              checks;
    int              failures;
    bit              check_en;
    logic            txr [96];
    vec_t            vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            fifo_uart_tx #(
                .DATA_WIDTH  (8),
                .CLKS_PER_BIT(CPB),
                .STOP_BITS   ((gi == 0) ? 1 : 2),
                .PARITY_EN   ((gi == 0) ? 0 : 1),
                .PARITY_ODD  ((gi == 2) ? 1 : 0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .fifo_empty(fifo_empty[gi]),
                .fifo_data (fifo_data[gi]),
                .fifo_r_en (fifo_r_en[gi]),
                .tx        (tx[gi]),
                .busy      (busy[gi]),
                .frame_done(frame_done[gi])
            );
        end
    endgenerate

    // FIFO models: registered data_out, valid the cycle after an accepted read.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (fifo_r_en[k] === 1'b1) begin
                fifo_data[k] <= mem[k][rd_ptr[k] % DEPTH];
                rd_ptr[k]    <= rd_ptr[k] + 1;
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        for (int k = 0; k < NI; k++) begin
            fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
        end
    end

    task automatic push(input int k, input logic [7:0] w);
        mem[k][wr_ptr[k] % DEPTH] = w;
        wr_ptr[k]++;
    endtask

    task automatic put(input int k, input obs_t o, input int cnt);
        repeat (cnt) begin
            frame_buf[k][fill_n] = o;
            fill_n++;
        end
    endtask

    // Predicts the outputs for the cycle after the coming edge from rst/enable and FIFO contents.
    task automatic model_step();
        logic [7:0] w;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                frame_len[k] = 0;
                frame_pos[k] = 0;
                exp_obs[k]   = 4'b1000;
            end else if (frame_pos[k] < frame_len[k]) begin
                exp_obs[k] = frame_buf[k][frame_pos[k]];
                frame_pos[k]++;
            end else if (enable && (wr_ptr[k] != model_rd[k])) begin
                w = mem[k][model_rd[k] % DEPTH];
                model_rd[k]++;
                fill_n = 0;
                put(k, 4'b1100, 1);                       // word arriving from the FIFO
                put(k, 4'b0100, CPB);                     // start bit
                for (int i = 0; i < 8; i++) put(k, {w[i], 3'b100}, CPB);
                if (k != 0) put(k, {(^w) ^ (k == 2), 3'b100}, CPB);
                put(k, 4'b1100, ((k == 0) ? 1 : 2) * CPB);
                put(k, 4'b1001, 1);                       // back in idle, completion pulse
                frame_len[k] = fill_n;
                frame_pos[k] = 0;
                exp_obs[k]   = 4'b1110;                   // read request cycle
            end else begin
                exp_obs[k] = 4'b1000;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        obs_t o;
        model_step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (fifo_r_en[k] === 1'b1) ren_cnt[k]++;
            if (frame_done[k] === 1'b1) done_cnt[k]++;
            if (check_en) begin
                o = {tx[k], busy[k], fifo_r_en[k], frame_done[k]};
                checks++;
                if (o !== exp_obs[k]) begin
                    failures++;
                    $display("FAIL model inst%0d t=%0t got=%b want=%b", k, $time, o, exp_obs[k]);
                end
            end
        end
    endtask

    task automatic wait_fall(input int k, output int n, output int first_ren);
        n = 0;
        first_ren = -1;
        do begin
            tick();
            n++;
            if (fifo_r_en[k] === 1'b1 && first_ren < 0) first_ren = n;
        end while (tx[k] !== 1'b0 && n < 300);
    endtask

    task automatic run_vec(input vec_t v, input bit do_push);
        int k, n, fr, done_at, nb;
        logic [15:0] got, want;
        k  = v.inst;
        nb = v.bits.len();
        ren_cnt[k]  = 0;
        done_cnt[k] = 0;
        if (do_push) push(k, v.word);
        wait_fall(k, n, fr);
        check("start_latency", n, 3);
        check("first_ren", fr, 1);
        got = '0;
        want = '0;
        done_at = -1;
        for (int c = 0; c <= nb * CPB + 1; c++) begin
            if (c > 0) tick();
            if (c % CPB == CPB / 2) got[c / CPB] = tx[k];
            if (frame_done[k] === 1'b1 && done_at < 0) done_at = c;
        end
        for (int i = 0; i < nb; i++) want[i] = (v.bits.getc(i) == "1");
        check("frame_bits", int'(got), int'(want));
        check("done_offset", done_at, nb * CPB);
        check("ren_pulses", ren_cnt[k], 1);
        check("done_pulses", done_cnt[k], 1);
        $display("frame inst=%0d word=0x%02h bits=%b", k, v.word, got);
    endtask

    initial begin
        int n, fr, fall2, idx, nw, len, k;
        logic [7:0] d;
        bit drained;

        vecs[0] = '{0, 8'hA5, "0101001011"};
        vecs[1] = '{1, 8'h07, "011100000111"};
        vecs[2] = '{2, 8'h07, "011100000011"};
        vecs[3] = '{0, 8'h3C, "0001111001"};
        vecs[4] = '{1, 8'h80, "000000001111"};
        vecs[5] = '{2, 8'h00, "000000000111"};
        vecs[6] = '{0, 8'h42, "0010000101"};

        for (int i = 0; i < NI; i++) begin
            wr_ptr[i] = 0; model_rd[i] = 0; frame_len[i] = 0; frame_pos[i] = 0;
            exp_obs[i] = 4'b1000; ren_cnt[i] = 0; done_cnt[i] = 0;
        end
        checks = 0;
        failures = 0;
        check_en = 1'b1;
        rst = 1'b1;
        enable = 1'b1;

        // Reset held with a word waiting: everything stays quiet.
        push(0, 8'hA5);
        repeat (5) begin
            tick();
            check("rst_hold", int'({tx[0], busy[0], fifo_r_en[0], frame_done[0]}), 4'b1000);
        end
        rst = 1'b0;
        run_vec(vecs[0], 1'b0);
        for (int i = 1; i < 6; i++) run_vec(vecs[i], 1'b1);

        // Back-to-back frames from a preloaded FIFO.
        ren_cnt[0] = 0;
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_fall(0, n, fr);
        txr[0] = tx[0];
        for (int c = 1; c < 96; c++) begin
            tick();
            txr[c] = tx[0];
        end
        fall2 = -1;
        for (int c = 37; c < 96; c++) if (fall2 < 0 && txr[c] == 1'b0) fall2 = c;
        check("b2b_gap", fall2 - 10 * CPB, 3);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            idx = fall2 + CPB * (i + 1) + CPB / 2;
            if (idx >= 0 && idx < 96) d[i] = txr[idx];
        end
        check("b2b_data2", int'(d), 8'hFF);
        check("b2b_ren", ren_cnt[0], 2);
        $display("b2b gap=%0d data2=0x%02h", fall2 - 10 * CPB, d);

        // enable dropped mid-frame with more data queued.
        push(0, 8'h5A);
        push(0, 8'h33);
        wait_fall(0, n, fr);
        repeat (10) tick();
        enable = 1'b0;
        ren_cnt[0] = 0;
        done_cnt[0] = 0;
        repeat (60) tick();
        check("dis_ren", ren_cnt[0], 0);
        check("dis_done", done_cnt[0], 1);
        check("dis_tx_idle", int'(tx[0]), 1);
        check("dis_busy", int'(busy[0]), 0);
        enable = 1'b1;
        tick();
        check("en_resume_ren", int'(fifo_r_en[0]), 1);
        repeat (50) tick();
        $display("enable drop frame completed, resume fetch seen");

        // Reset during data bit 3.
        push(0, 8'h96);
        wait_fall(0, n, fr);
        repeat (17) tick();
        check("rst_pre_busy", int'(busy[0]), 1);
        rst = 1'b1;
        done_cnt[0] = 0;
        tick();
        check("rst_mid_tx", int'(tx[0]), 1);
        check("rst_mid_busy", int'(busy[0]), 0);
        rst = 1'b0;
        repeat (50) tick();
        check("rst_no_done", done_cnt[0], 0);
        run_vec(vecs[6], 1'b1);

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            k  = int'($urandom_range(0, NI - 1));
            nw = int'($urandom_range(0, 3));
            for (int j = 0; j < nw; j++) begin
                if (wr_ptr[k] - rd_ptr[k] < 48) push(k, 8'($urandom));
            end
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            len = int'($urandom_range(5, 120));
            repeat (len) tick();
            $display("rand it=%0d inst=%0d pushed=%0d enable=%0b cycles=%0d", it, k, nw, enable, len);
        end
        enable = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 3000 && !drained; c++) begin
            tick();
            drained = (fifo_empty == '1) && (busy == '0);
        end
        check("drain", int'(drained), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
